// File: rtl/ifetch_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_pkg
//
// Shared definitions for the instruction-fetch unit.
//
// Contents:
//   state_t          fetch FSM states (S_RUN, S_FAULT)
//   RESET_PC_DEF     default first fetch address after reset
//   IROM_DEPTH_DEF   default log2 of the instruction ROM size in words
//   INST_BYTES       bytes per RV32I instruction (PC step)
// -----------------------------------------------------------------------------
package ifetch_pkg;

   typedef enum logic [0:0] {
      S_RUN   = 1'b0,
      S_FAULT = 1'b1
   } state_t;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam int          IROM_DEPTH_DEF = 10;
   localparam logic [31:0] INST_BYTES     = 32'd4;

endpackage : ifetch_pkg

// File: rtl/ifetch_addr_check.sv
// -----------------------------------------------------------------------------
// ifetch_addr_check
//
// Purely combinational legality check for a fetch byte address. An address is
// bad when it is not word aligned or when its word index lies beyond the end
// of a ROM holding 2**IROM_DEPTH words.
//
// Parameters:
//   IROM_DEPTH   log2 of ROM words (1..30)
//
// Ports:
//   i_addr   in   32  candidate fetch byte address
//   o_bad    out  1   address is misaligned or out of range
// -----------------------------------------------------------------------------
module ifetch_addr_check
   import ifetch_pkg::*;
#(
   parameter int IROM_DEPTH = IROM_DEPTH_DEF
) (
   input  logic [31:0] i_addr,
   output logic        o_bad
);

   logic [29:0] w_word;
   logic [29:0] w_word_hi;
   logic        w_misaligned;
   logic        w_out_of_range;

   assign w_word = i_addr[31:2];

   // Any word-index bit at or above IROM_DEPTH set means index >= 2**IROM_DEPTH.
   assign w_word_hi      = w_word >> IROM_DEPTH;
   assign w_misaligned   = |i_addr[1:0];
   assign w_out_of_range = |w_word_hi;

   assign o_bad = w_misaligned | w_out_of_range;

endmodule : ifetch_addr_check

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
//
// Instruction-fetch initiator for the pipelined RV32I core. Owns the PC,
// issues word reads to a synchronous instruction ROM (one-cycle read latency)
// and presents each returned instruction together with its PC to decode.
// Handles stall backpressure, branch/jump redirects, invalid fetch addresses
// (misaligned or past the ROM end) and counts issued ROM reads.
//
// Handshake: o_if_valid qualifies o_if_pc/o_if_inst. i_stall is the inverted
// ready of the decode stage: while it is high the presented instruction is not
// consumed, so every register holds and no ROM read is issued. The ROM output
// holds with the registers because it is only updated by enabled reads, so
// o_if_inst stays coherent with o_if_pc across a stall. i_redirect overrides
// i_stall and does not squash the instruction currently presented; pipeline
// control flushes IF/ID in the redirect cycle.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//   IROM_DEPTH   log2 of ROM words; legal byte addresses 0 .. 4*2**IROM_DEPTH-4
//
// Ports:
//   i_clk            in   1   rising-edge clock
//   i_rst            in   1   synchronous active-high reset
//   i_stall          in   1   decode cannot accept; hold everything
//   i_redirect       in   1   branch/jump taken; overrides i_stall
//   i_redirect_pc    in   32  redirect target byte address
//   o_irom_en        out  1   ROM read enable
//   o_irom_adr       out  32  ROM byte address (ROM indexes with [31:2])
//   i_irom_inst      in   32  ROM data, valid the cycle after an enabled read
//   o_if_valid       out  1   o_if_inst/o_if_pc hold a real instruction
//   o_if_pc          out  32  PC of presented instruction or faulting address
//   o_if_inst        out  32  instruction word (pass-through of i_irom_inst)
//   o_if_err         out  1   fetch fault presented
//   o_fetch_count    out  32  number of ROM reads issued (wraps)
//   o_dbg_state      out  1   current FSM state (0 = S_RUN, 1 = S_FAULT)
// -----------------------------------------------------------------------------
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int          IROM_DEPTH = IROM_DEPTH_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_irom_en,
   output logic [31:0] o_irom_adr,
   input  logic [31:0] i_irom_inst,
   output logic        o_if_valid,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_inst,
   output logic        o_if_err,
   output logic [31:0] o_fetch_count,
   output logic        o_dbg_state
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t      r_state;
   logic [31:0] r_pc;            // next sequential fetch address
   logic [31:0] r_req_pc;        // address of the last issue attempt
   logic        r_req_v;         // last attempt was a real ROM read
   logic [31:0] r_fetch_count;

   state_t      w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_req_pc_nxt;
   logic        w_req_v_nxt;
   logic [31:0] w_fetch_count_nxt;

   logic [31:0] w_addr;          // issue address this cycle
   logic        w_bad;           // issue address is illegal
   logic        w_attempt;       // this cycle tries to fetch w_addr
   logic        w_issue;         // this cycle actually reads the ROM

   // Redirect target takes the place of the sequential PC with no bubble.
   assign w_addr = i_redirect ? i_redirect_pc : r_pc;

   ifetch_addr_check #(
      .IROM_DEPTH (IROM_DEPTH)
   ) u_addr_check (
      .i_addr (w_addr),
      .o_bad  (w_bad)
   );

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_req_pc_nxt      = r_req_pc;
      w_req_v_nxt       = r_req_v;
      w_fetch_count_nxt = r_fetch_count;
      w_issue           = 1'b0;

      // A redirect always attempts; otherwise only a running, unstalled unit
      // attempts. S_FAULT is sticky until a redirect (or reset) arrives.
      w_attempt = i_redirect | (~i_stall & (r_state == S_RUN));

      if (w_attempt) begin
         w_req_pc_nxt = w_addr;
         if (!w_bad) begin
            w_issue           = 1'b1;
            w_req_v_nxt       = 1'b1;
            w_pc_nxt          = w_addr + INST_BYTES;
            w_state_nxt       = S_RUN;
            w_fetch_count_nxt = r_fetch_count + 32'd1;
         end else begin
            // The faulting address is kept in r_req_pc so decode can report it.
            w_req_v_nxt = 1'b0;
            w_state_nxt = S_FAULT;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_RUN;
         r_pc          <= RESET_PC;
         r_req_pc      <= RESET_PC;
         r_req_v       <= 1'b0;
         r_fetch_count <= 32'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_req_pc      <= w_req_pc_nxt;
         r_req_v       <= w_req_v_nxt;
         r_fetch_count <= w_fetch_count_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Reset suppresses the read so the in-flight slot is empty after reset.
   assign o_irom_en     = w_issue & ~i_rst;
   assign o_irom_adr    = w_addr;

   assign o_if_valid    = r_req_v & (r_state == S_RUN);
   assign o_if_err      = (r_state == S_FAULT);
   assign o_if_pc       = r_req_pc;
   assign o_if_inst     = i_irom_inst;
   assign o_fetch_count = r_fetch_count;
   assign o_dbg_state   = r_state;

endmodule : ifetch_unit

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
//
// Directed steps from the fetch-unit test plan followed by a randomized phase.
// A synchronous ROM model holds word i = 0x1000_0000 + i. Expected behaviour
// comes from a cycle-level reference of the fetch rules: next address,
// presented address, presented-valid, fault flag and fetch count.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;
   import ifetch_pkg::*;

   localparam int          DEPTH     = 10;
   localparam logic [31:0] RPC       = 32'h0000_0000;
   localparam logic [31:0] ROM_BYTES = 32'd4 << DEPTH;
   localparam logic [31:0] INST_BASE = 32'h1000_0000;

   // Clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        irom_en;
   logic [31:0] irom_adr;
   logic [31:0] irom_inst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_err;
   logic [31:0] fetch_count;
   logic        dbg_state;

   ifetch_unit #(
      .RESET_PC   (RPC),
      .IROM_DEPTH (DEPTH)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_irom_en     (irom_en),
      .o_irom_adr    (irom_adr),
      .i_irom_inst   (irom_inst),
      .o_if_valid    (if_valid),
      .o_if_pc       (if_pc),
      .o_if_inst     (if_inst),
      .o_if_err      (if_err),
      .o_fetch_count (fetch_count),
      .o_dbg_state   (dbg_state)
   );

   // Synchronous ROM model: output only changes on an enabled read.
   logic [31:0] rom [0:1023];
   logic [31:0] rom_q;
   initial for (int i = 0; i < 1024; i++) rom[i] = INST_BASE + i;
   always @(posedge clk) if (irom_en) rom_q <= rom[irom_adr[11:2]];
   assign irom_inst = rom_q;

   // Reference model state
   logic [31:0] m_next  = RPC;
   logic [31:0] m_pc    = RPC;
   bit          m_v     = 1'b0;
   bit          m_fault = 1'b0;
   logic [31:0] m_count = 32'd0;

   int n_checks = 0;
   int n_errors = 0;

   function automatic bit good(input logic [31:0] a);
      return (a % 4 == 0) && (a < ROM_BYTES);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check the combinational ROM request,
   // advance the reference across the edge, check presented outputs.
   task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t);
      logic [31:0] a;
      bit          tries;
      bit          en;
      @(negedge clk);
      rst = r; stall = s; redirect = d; redirect_pc = t;
      #1;
      a     = d ? t : m_next;
      tries = d || (!s && !m_fault);
      en    = !r && tries && good(a);
      chk("irom_en", {31'b0, irom_en}, {31'b0, en});
      if (en) chk("irom_adr", irom_adr, a);
      @(posedge clk);
      if (r) begin
         m_next = RPC; m_pc = RPC; m_v = 0; m_fault = 0; m_count = 0;
      end else if (tries) begin
         m_pc = a;
         if (good(a)) begin
            m_v = 1; m_fault = 0; m_next = a + 4; m_count = m_count + 1;
         end else begin
            m_v = 0; m_fault = 1;
         end
      end
      #1;
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_v && !m_fault});
      chk("if_err", {31'b0, if_err}, {31'b0, m_fault});
      chk("dbg_state", {31'b0, dbg_state}, {31'b0, m_fault});
      chk("if_pc", if_pc, m_pc);
      chk("fetch_count", fetch_count, m_count);
      if (m_v && !m_fault) chk("if_inst", if_inst, INST_BASE + (m_pc >> 2));
   endtask

   initial begin
      logic [31:0] tgt;
      bit          r, s, d;

      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

      // Reset
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_pc", if_pc, RPC);
      chk("rst_count", fetch_count, 32'd0);

      // Release: pc 0,4,8 then stall 3 cycles with pc 8 presented, then pc 12
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("pc8", if_pc, 32'h8);
      repeat (3) begin
         step(0, 1, 0, 0);
         chk("stall_pc", if_pc, 32'h8);
         chk("stall_inst", if_inst, INST_BASE + 2);
         chk("stall_count", fetch_count, 32'd3);
      end
      step(0, 0, 0, 0);
      chk("pc12", if_pc, 32'hC);
      chk("inst12", if_inst, INST_BASE + 3);
      chk("count4", fetch_count, 32'd4);

      // Redirect with stall: redirect wins
      step(0, 1, 1, 32'h40);
      chk("redir_pc", if_pc, 32'h40);
      chk("redir_inst", if_inst, INST_BASE + 16);
      step(0, 0, 0, 0);
      chk("redir_next", if_pc, 32'h44);

      // Misaligned redirect: sticky fault until redirect to 0
      step(0, 0, 1, 32'h42);
      chk("mis_err", {31'b0, if_err}, 32'd1);
      chk("mis_pc", if_pc, 32'h42);
      repeat (3) step(0, 0, 0, 0);
      chk("mis_hold", if_pc, 32'h42);
      step(0, 0, 1, 32'h0);
      chk("recover_pc", if_pc, 32'h0);
      chk("recover_valid", {31'b0, if_valid}, 32'd1);

      // Run off the ROM end
      step(0, 0, 1, 32'hFF0);
      repeat (3) step(0, 0, 0, 0);
      chk("end_pc", if_pc, 32'hFFC);
      chk("end_valid", {31'b0, if_valid}, 32'd1);
      step(0, 0, 0, 0);
      chk("off_err", {31'b0, if_err}, 32'd1);
      chk("off_pc", if_pc, 32'h1000);

      // Reset during fault, then during stall
      step(1, 0, 0, 0);
      chk("rstf_err", {31'b0, if_err}, 32'd0);
      chk("rstf_pc", if_pc, RPC);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("rsts_valid", {31'b0, if_valid}, 32'd0);
      chk("rsts_count", fetch_count, 32'd0);
      step(0, 0, 0, 0);
      chk("restart_pc", if_pc, RPC);

      // Randomized phase
      for (int n = 0; n < 600; n++) begin
         r = ($urandom_range(0, 99) < 2);
         s = ($urandom_range(0, 99) < 25);
         d = ($urandom_range(0, 99) < 12);
         case ($urandom_range(0, 3))
            0:       tgt = 32'($urandom_range(0, 1023)) << 2;
            1:       tgt = ROM_BYTES - 32'(4 * $urandom_range(1, 3));
            2:       tgt = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
            default: tgt = $urandom();
         endcase
         step(r, s, d, tgt);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_ifetch_unit
